// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the parametrised UART receiver.
//   rx_state_t : receiver FSM states
//   rx_word_t  : one received word with its error flags (widest data size)
//   clamp_len  : clamps the runtime frame length into [MIN_DATA_LEN, max]
// ----------------------------------------------------------------------------
package uart_pkg;

    localparam int MIN_DATA_LEN = 5;
    localparam int MIN_OSR      = 4;
    localparam int MAX_DATA_W   = 9;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } rx_state_t;

    typedef struct packed {
        logic                  ferr;
        logic                  perr;
        logic [MAX_DATA_W-1:0] data;
    } rx_word_t;

    function automatic logic [3:0] clamp_len(input logic [3:0] len, input int max_len);
        if (int'(len) < MIN_DATA_LEN) return 4'(MIN_DATA_LEN);
        else if (int'(len) > max_len) return 4'(max_len);
        else return len;
    endfunction

endpackage

// File: rtl/uart_rx_sync_fifo.sv
// ----------------------------------------------------------------------------
// uart_rx_sync_fifo
// Single-clock FIFO with flush, full/empty flags and an occupancy count.
// A push while full is only accepted when a pop happens in the same cycle;
// deciding what a refused push means is left to the instantiating block.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   flush       empties the FIFO (priority over push/pop)
//   push, wdata write request and word
//   pop         read request (ignored when empty)
//   rdata       word at the head (valid when !empty)
//   full, empty status flags
//   level       number of occupied entries
// ----------------------------------------------------------------------------
module uart_rx_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             wr_en;
    logic             rd_en;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign level = count;
    assign rdata = mem[rd_ptr];

    // A full FIFO still takes a word when the head leaves in the same cycle.
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;

    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            unique case ({wr_en, rd_en})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; an entry is only observed after it
    // has been written, and leaving it unreset lets it map onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_en && !flush) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/uart_rx_param.sv
// ----------------------------------------------------------------------------
// uart_rx_param
// Oversampling UART receiver with runtime frame format and a receive FIFO.
// Each word is stored with its framing (ferr) and parity (perr) error flags.
// Optional feature macro: UART_RX_BREAK_DET_EN adds the break_det output and
// the ST_BREAK state; without it a break frame is stored as data 0 with ferr.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   enable, rx_enable        both high to receive; either low aborts a frame
//   parity_enable/odd        parity bit present / odd parity
//   data_len                 data bits per frame, clamped to [5,DATA_W]
//   stop_2                   two stop bits
//   osr_tick, osr_value      oversample strobe and ticks per bit
//   rxd                      asynchronous serial input
//   fifo_flush               empties the receive FIFO
//   rx_valid/rx_ready        pop handshake for the FIFO head
//   rx_data, rx_ferr, rx_perr head word and its error flags (0 when empty)
//   fifo_level               occupied FIFO entries
//   overrun                  1-cycle pulse when a word was dropped (FIFO full)
//   busy                     a frame is in progress
//   break_det                1-cycle pulse on a break frame (macro only)
// ----------------------------------------------------------------------------
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int OSR_W      = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          rx_enable,
    input  logic                          parity_enable,
    input  logic                          parity_odd,
    input  logic [3:0]                    data_len,
    input  logic                          stop_2,
    input  logic                          osr_tick,
    input  logic [OSR_W-1:0]              osr_value,
    input  logic                          rxd,
    input  logic                          fifo_flush,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [DATA_W-1:0]             rx_data,
    output logic                          rx_ferr,
    output logic                          rx_perr,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overrun,
    output logic                          busy
`ifdef UART_RX_BREAK_DET_EN
    ,
    output logic                          break_det
`endif
);

    rx_state_t          state;
    logic               rx_meta, rx_sync, rx_prev;
    logic [OSR_W-1:0]   osr_lat, osr_eff, cnt;
    logic [3:0]         len_lat, bit_idx;
    logic [DATA_W-1:0]  data_r;
    logic               par_acc, perr_r, ferr_r, stop_second;
    logic               active, start_edge, sample, stop_ferr, last_stop, push_req;
    logic               fifo_full, fifo_empty, pop;
    logic [DATA_W+1:0]  fifo_wdata, head;
`ifdef UART_RX_BREAK_DET_EN
    logic               par_zero;
    logic               is_break;
`endif

    assign active     = enable && rx_enable;
    assign start_edge = rx_prev && !rx_sync;
    // Values below MIN_OSR are unsupported; treating them as MIN_OSR keeps the
    // half-bit counter load from underflowing.
    assign osr_eff    = (osr_value < OSR_W'(MIN_OSR)) ? OSR_W'(MIN_OSR) : osr_value;
    assign busy       = (state != ST_IDLE);

    // Two-flop synchroniser plus one history flop for 1->0 edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rxd;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can leave
    // it unassigned and infer a latch.
    always_comb begin
        sample    = osr_tick && (cnt == '0);
        stop_ferr = ferr_r || !rx_sync;
        last_stop = (state == ST_STOP) && sample && (!stop_2 || stop_second);
`ifdef UART_RX_BREAK_DET_EN
        is_break  = (state == ST_STOP) && sample && !stop_second &&
                    (data_r == '0) && par_zero && !rx_sync;
        push_req  = active && last_stop && !is_break;
`else
        push_req  = active && last_stop;
`endif
    end

    assign fifo_wdata = {stop_ferr, perr_r, data_r};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            osr_lat     <= '0;
            len_lat     <= '0;
            cnt         <= '0;
            bit_idx     <= '0;
            data_r      <= '0;
            par_acc     <= 1'b0;
            perr_r      <= 1'b0;
            ferr_r      <= 1'b0;
            stop_second <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            par_zero    <= 1'b1;
`endif
        end else if (!active) begin
            state <= ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start_edge) begin
                        osr_lat     <= osr_eff;
                        len_lat     <= clamp_len(data_len, DATA_W);
                        // Counter counts down and samples on the tick where it is 0.
                        cnt         <= (osr_eff >> 1) - OSR_W'(1);
                        data_r      <= '0;
                        par_acc     <= 1'b0;
                        perr_r      <= 1'b0;
                        ferr_r      <= 1'b0;
                        stop_second <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
                        par_zero    <= 1'b1;
`endif
                        state       <= ST_START;
                    end
                end
                ST_START: begin
                    if (osr_tick) begin
                        if (cnt != '0) begin
                            cnt <= cnt - OSR_W'(1);
                        end else if (!rx_sync) begin
                            cnt     <= osr_lat - OSR_W'(1);
                            bit_idx <= '0;
                            state   <= ST_DATA;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_DATA: begin
                    if (osr_tick) begin
                        if (cnt != '0) begin
                            cnt <= cnt - OSR_W'(1);
                        end else begin
                            data_r  <= data_r | (DATA_W'(rx_sync) << bit_idx);
                            par_acc <= par_acc ^ rx_sync;
                            cnt     <= osr_lat - OSR_W'(1);
                            bit_idx <= bit_idx + 4'd1;
                            if (bit_idx == len_lat - 4'd1)
                                state <= parity_enable ? ST_PARITY : ST_STOP;
                        end
                    end
                end
                ST_PARITY: begin
                    if (osr_tick) begin
                        if (cnt != '0) begin
                            cnt <= cnt - OSR_W'(1);
                        end else begin
                            perr_r <= (rx_sync != (parity_odd ? !par_acc : par_acc));
`ifdef UART_RX_BREAK_DET_EN
                            par_zero <= !rx_sync;
`endif
                            cnt    <= osr_lat - OSR_W'(1);
                            state  <= ST_STOP;
                        end
                    end
                end
                ST_STOP: begin
                    if (osr_tick) begin
                        if (cnt != '0) begin
                            cnt <= cnt - OSR_W'(1);
`ifdef UART_RX_BREAK_DET_EN
                        end else if (is_break) begin
                            state <= ST_BREAK;
`endif
                        end else if (stop_2 && !stop_second) begin
                            stop_second <= 1'b1;
                            ferr_r      <= stop_ferr;
                            cnt         <= osr_lat - OSR_W'(1);
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
`ifdef UART_RX_BREAK_DET_EN
                ST_BREAK: begin
                    if (rx_sync) state <= ST_IDLE;
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign pop = rx_valid && rx_ready;

    uart_rx_sync_fifo #(
        .WIDTH (DATA_W + 2),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (fifo_flush),
        .push  (push_req),
        .wdata (fifo_wdata),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // Head fields are masked while empty so the outputs read 0 out of reset.
    assign rx_valid = !fifo_empty;
    assign rx_data  = rx_valid ? head[DATA_W-1:0] : '0;
    assign rx_perr  = rx_valid && head[DATA_W];
    assign rx_ferr  = rx_valid && head[DATA_W+1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun <= 1'b0;
        end else begin
            overrun <= push_req && fifo_full && !pop && !fifo_flush;
        end
    end

`ifdef UART_RX_BREAK_DET_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            break_det <= 1'b0;
        end else begin
            break_det <= active && is_break;
        end
    end
`endif

endmodule
